// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: pad synchroniser, stability-counter debounce, and registered
// press / release / long-press strobes plus a clean pressed level.
//
// state        | meaning
// IDLE         | key released and stable, Level=0
// PRESS_WAIT   | pressed level seen, waiting for it to stay stable
// PRESSED      | press accepted, hold timer running
// HELD_LONG    | long-press strobe already issued, hold timer frozen
// RELEASE_WAIT | released level seen while pressed, waiting for it to stay stable
module key_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter bit ACTIVE_LOW_IN   = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic ButtonIn,
   output logic ButtonOut,
   output logic ReleaseOut,
   output logic LongOut,
   output logic Level
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(LONG_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      HELD_LONG,
      RELEASE_WAIT
   } state_t;

   state_t          state, state_n;
   logic [DW-1:0]   deb_cnt, deb_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic            long_done, long_done_n;
   logic            press_n, release_n, long_n, level_n;
   logic            pad_pressed;
   logic            sync_q, btn_s;

   assign pad_pressed = ACTIVE_LOW_IN ? ~ButtonIn : ButtonIn;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q     <= 1'b0;
         btn_s      <= 1'b0;
         state      <= IDLE;
         deb_cnt    <= '0;
         hold_cnt   <= '0;
         long_done  <= 1'b0;
         ButtonOut  <= 1'b0;
         ReleaseOut <= 1'b0;
         LongOut    <= 1'b0;
         Level      <= 1'b0;
      end else begin
         sync_q     <= pad_pressed;
         btn_s      <= sync_q;
         state      <= state_n;
         deb_cnt    <= deb_n;
         hold_cnt   <= hold_n;
         long_done  <= long_done_n;
         ButtonOut  <= press_n;
         ReleaseOut <= release_n;
         LongOut    <= long_n;
         Level      <= level_n;
      end
   end

   always_comb begin
      state_n     = state;
      deb_n       = deb_cnt;
      hold_n      = hold_cnt;
      long_done_n = long_done;
      press_n     = 1'b0;
      release_n   = 1'b0;
      long_n      = 1'b0;
      level_n     = Level;

      case (state)
         IDLE: begin
            level_n = 1'b0;
            if (btn_s) begin
               state_n = PRESS_WAIT;
               deb_n   = '0;
            end
         end

         PRESS_WAIT: begin
            if (!btn_s) begin
               state_n = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_n     = PRESSED;
               press_n     = 1'b1;
               level_n     = 1'b1;
               hold_n      = '0;
               long_done_n = 1'b0;
            end else begin
               deb_n = deb_cnt + DW'(1);
            end
         end

         PRESSED: begin
            if (!btn_s) begin
               state_n = RELEASE_WAIT;
               deb_n   = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_n     = HELD_LONG;
               long_n      = 1'b1;
               long_done_n = 1'b1;
            end else begin
               hold_n = hold_cnt + HW'(1);
            end
         end

         HELD_LONG: begin
            if (!btn_s) begin
               state_n = RELEASE_WAIT;
               deb_n   = '0;
            end
         end

         RELEASE_WAIT: begin
            // a release bounce returns to whichever pressed state we came from
            if (btn_s) begin
               state_n = long_done ? HELD_LONG : PRESSED;
            end else if (deb_cnt == DEB_LAST) begin
               state_n   = IDLE;
               release_n = 1'b1;
               level_n   = 1'b0;
            end else begin
               deb_n = deb_cnt + DW'(1);
            end
         end

         default: begin
            state_n = IDLE;
            level_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: run-length reference model checked every cycle, directed
// scenarios with hand-computed strobe timing, then randomized pad activity with resets.
module tb_key_debounce_pulse;

   localparam int D = 4;
   localparam int L = 10;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic ButtonIn = 1'b1;
   logic ButtonOut, ReleaseOut, LongOut, Level;

   key_debounce_pulse #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES    (L),
      .ACTIVE_LOW_IN  (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ButtonIn  (ButtonIn),
      .ButtonOut (ButtonOut),
      .ReleaseOut(ReleaseOut),
      .LongOut   (LongOut),
      .Level     (Level)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: the pad value seen two edges late; an accepted level flips once the
   // opposite value has been seen on D+1 consecutive edges; hold time accrues only on edges
   // where the key is accepted, stably pressed and not yet long.
   int  run, hold;
   bit  p1, p2, acc, ldone;
   bit  e_press, e_rel, e_long;

   always @(posedge clk) begin
      cyc++;
      if (!reset) begin
         p1 = 0; p2 = 0; acc = 0; run = 0; hold = 0; ldone = 0;
         e_press = 0; e_rel = 0; e_long = 0;
      end else begin
         bit seen;
         seen    = p2;
         e_press = 0; e_rel = 0; e_long = 0;
         if (seen != acc) begin
            run++;
            if (run == D + 1) begin
               acc = seen;
               run = 0;
               if (acc) begin
                  e_press = 1; hold = 0; ldone = 0;
               end else begin
                  e_rel = 1;
               end
            end
         end else begin
            if (acc && run == 0 && !ldone) begin
               hold++;
               if (hold == L) begin
                  e_long = 1; ldone = 1;
               end
            end
            run = 0;
         end
         p2 = p1;
         p1 = ~ButtonIn;
      end
   end

   int n_press = 0, n_rel = 0, n_long = 0;
   int press_cyc = -1, rel_cyc = -1, long_cyc = -1;

   always @(negedge clk) begin
      if (cyc > 0) begin
         check("ButtonOut", ButtonOut, e_press);
         check("ReleaseOut", ReleaseOut, e_rel);
         check("LongOut", LongOut, e_long);
         check("Level", Level, acc);
         if (ButtonOut)  begin n_press++; press_cyc = cyc; end
         if (ReleaseOut) begin n_rel++;   rel_cyc   = cyc; end
         if (LongOut)    begin n_long++;  long_cyc  = cyc; end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t0, t1, bp, br, bl;

      step(3);
      check("reset_level", Level, 0);
      check("reset_strobes", ButtonOut + ReleaseOut + LongOut, 0);
      reset = 1'b1;
      step(3);

      // clean short press: low 12 cycles, then release
      bp = n_press; br = n_rel; bl = n_long;
      t0 = cyc; ButtonIn = 1'b0;
      step(12);
      check("t1_press_cycle", press_cyc, t0 + 7);
      check("t1_level_high", Level, 1);
      t1 = cyc; ButtonIn = 1'b1;
      step(12);
      check("t1_release_cycle", rel_cyc, t1 + 7);
      check("t1_level_low", Level, 0);
      check("t1_no_long", n_long - bl, 0);
      check("t1_counts", (n_press - bp) * 10 + (n_rel - br), 11);

      // press bounce: low 3, high 1, low held
      bp = n_press;
      ButtonIn = 1'b0; step(3);
      ButtonIn = 1'b1; step(1);
      t0 = cyc; ButtonIn = 1'b0;
      step(12);
      check("t2_single_press", n_press - bp, 1);
      check("t2_press_cycle", press_cyc, t0 + 7);
      ButtonIn = 1'b1; step(12);

      // long press, then release
      bp = n_press; br = n_rel; bl = n_long;
      t0 = cyc; ButtonIn = 1'b0;
      step(20);
      check("t3_press_cycle", press_cyc, t0 + 7);
      check("t3_long_cycle", long_cyc, t0 + 17);
      check("t3_one_long", n_long - bl, 1);
      t1 = cyc; ButtonIn = 1'b1;
      step(10);
      check("t3_release_cycle", rel_cyc, t1 + 7);
      check("t3_level_low", Level, 0);
      step(4);

      // release bounce while held long
      br = n_rel; bl = n_long;
      ButtonIn = 1'b0; step(20);
      ButtonIn = 1'b1; step(2);
      ButtonIn = 1'b0; step(10);
      check("t5_no_release", n_rel - br, 0);
      check("t5_one_long", n_long - bl, 1);
      check("t5_level_held", Level, 1);
      ButtonIn = 1'b1; step(12);

      // reset mid-hold at edge 9 of the press
      bp = n_press; br = n_rel;
      t0 = cyc; ButtonIn = 1'b0;
      step(8);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      check("t6_level_cleared", Level, 0);
      step(10);
      check("t6_repress_cycle", press_cyc, t0 + 16);
      check("t6_two_presses", n_press - bp, 2);
      check("t6_no_release", n_rel - br, 0);
      ButtonIn = 1'b1; step(12);

      // randomized pad activity with occasional resets
      for (int i = 0; i < 400; i++) begin
         ButtonIn = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0; step(1); reset = 1'b1;
         end
         step($urandom_range(1, 16));
      end

      ButtonIn = 1'b1;
      step(12);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
